// File: rtl/scarv_cop_dispatch_if.sv
// Pipeline-side and COP-side handshake bundle for scarv_cop_dispatch.
// The dispatcher takes the master modport; the pipeline/COP peer takes slave.
interface scarv_cop_dispatch_if;
  logic        pipe_valid;
  logic        pipe_ready;
  logic [31:0] pipe_insn;
  logic [31:0] pipe_rs1;
  logic        pipe_flush;
  logic        res_valid;
  logic        res_ready;
  logic        res_wen;
  logic [4:0]  res_waddr;
  logic [31:0] res_wdata;
  logic [2:0]  res_result;
  logic        res_timeout;
  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic        cpu_abort_req;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;
  logic        cop_insn_rsp;
  logic        cpu_insn_ack;
  logic        busy;

  modport master (
    input  pipe_valid, pipe_insn, pipe_rs1, pipe_flush, res_ready,
    input  cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
    output pipe_ready, res_valid, res_wen, res_waddr, res_wdata, res_result, res_timeout,
    output cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack, busy
  );

  modport slave (
    output pipe_valid, pipe_insn, pipe_rs1, pipe_flush, res_ready,
    output cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
    input  pipe_ready, res_valid, res_wen, res_waddr, res_wdata, res_result, res_timeout,
    input  cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack, busy
  );
endinterface

// File: rtl/scarv_cop_dispatch.sv
// Issue/retire sequencer between the host pipeline and the SCARV COP; all outputs registered.
// Define SCARV_COP_DISPATCH_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module scarv_cop_dispatch #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  scarv_cop_dispatch_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESULT} state_t;

  state_t      state_q, state_d;
  logic        pipe_ready_q, pipe_ready_d;
  logic        req_q, req_d;
  logic        abort_q, abort_d;
  logic        ack_q;
  logic        busy_q, busy_d;
  logic        discard_q, discard_d;
  logic [31:0] enc_q, enc_d;
  logic [31:0] rs1_q, rs1_d;
  logic        res_valid_q, res_valid_d;
  logic        res_wen_q, res_wen_d;
  logic [4:0]  res_waddr_q, res_waddr_d;
  logic [31:0] res_wdata_q, res_wdata_d;
  logic [2:0]  res_result_q, res_result_d;
  logic        res_timeout_q, res_timeout_d;
  logic        tmo_hit;
  logic        go_tmo;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
  // Counter holds the number of the current ISSUE/WAIT_RSP cycle, starting at 1.
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == ISSUE) cnt_d = 16'd1;
    else if (state_q == ISSUE || state_q == WAIT_RSP) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) cnt_q <= 16'd0;
    else           cnt_q <= cnt_d;
  end

  assign tmo_hit = (state_q == ISSUE || state_q == WAIT_RSP) && (cnt_q == 16'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    abort_d       = 1'b0;
    discard_d     = discard_q;
    enc_d         = enc_q;
    rs1_d         = rs1_q;
    res_wen_d     = res_wen_q;
    res_waddr_d   = res_waddr_q;
    res_wdata_d   = res_wdata_q;
    res_result_d  = res_result_q;
    res_timeout_d = res_timeout_q;
    go_tmo        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pipe_ready_q && bus.pipe_valid && !bus.pipe_flush) begin
          enc_d     = bus.pipe_insn;
          rs1_d     = bus.pipe_rs1;
          req_d     = 1'b1;
          discard_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // An acknowledged instruction belongs to the COP, so a flush must abort it.
        if (req_q && bus.cop_insn_ack) begin
          req_d = 1'b0;
          if (tmo_hit) begin
            abort_d = 1'b1;
            if (bus.pipe_flush) state_d = IDLE;
            else                go_tmo  = 1'b1;
          end else begin
            state_d = WAIT_RSP;
            if (bus.pipe_flush) begin
              abort_d   = 1'b1;
              discard_d = 1'b1;
            end
          end
        end else if (bus.pipe_flush) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          abort_d = 1'b1;
          go_tmo  = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (bus.cop_insn_rsp) begin
          if (discard_q || bus.pipe_flush) begin
            state_d = IDLE;
          end else begin
            res_wen_d     = bus.cop_wen;
            res_waddr_d   = bus.cop_waddr;
            res_wdata_d   = bus.cop_wdata;
            res_result_d  = bus.cop_result;
            res_timeout_d = 1'b0;
            state_d       = RESULT;
          end
        end else if (tmo_hit) begin
          abort_d = !discard_q;
          if (discard_q || bus.pipe_flush) state_d = IDLE;
          else                             go_tmo  = 1'b1;
        end else if (bus.pipe_flush && !discard_q) begin
          abort_d   = 1'b1;
          discard_d = 1'b1;
        end
      end
      RESULT: begin
        if (bus.pipe_flush || bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (go_tmo) begin
      state_d       = RESULT;
      res_wen_d     = 1'b0;
      res_waddr_d   = 5'd0;
      res_wdata_d   = 32'd0;
      res_result_d  = 3'd0;
      res_timeout_d = 1'b1;
    end
    pipe_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    res_valid_d  = (state_d == RESULT);
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q       <= IDLE;
      pipe_ready_q  <= 1'b0;
      req_q         <= 1'b0;
      abort_q       <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      discard_q     <= 1'b0;
      enc_q         <= 32'd0;
      rs1_q         <= 32'd0;
      res_valid_q   <= 1'b0;
      res_wen_q     <= 1'b0;
      res_waddr_q   <= 5'd0;
      res_wdata_q   <= 32'd0;
      res_result_q  <= 3'd0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pipe_ready_q  <= pipe_ready_d;
      req_q         <= req_d;
      abort_q       <= abort_d;
      ack_q         <= 1'b1;
      busy_q        <= busy_d;
      discard_q     <= discard_d;
      enc_q         <= enc_d;
      rs1_q         <= rs1_d;
      res_valid_q   <= res_valid_d;
      res_wen_q     <= res_wen_d;
      res_waddr_q   <= res_waddr_d;
      res_wdata_q   <= res_wdata_d;
      res_result_q  <= res_result_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign bus.pipe_ready    = pipe_ready_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_wen       = res_wen_q;
  assign bus.res_waddr     = res_waddr_q;
  assign bus.res_wdata     = res_wdata_q;
  assign bus.res_result    = res_result_q;
  assign bus.res_timeout   = res_timeout_q;
  assign bus.cpu_insn_req  = req_q;
  assign bus.cpu_abort_req = abort_q;
  assign bus.cpu_insn_enc  = enc_q;
  assign bus.cpu_rs1       = rs1_q;
  assign bus.cpu_insn_ack  = ack_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Directed bench for scarv_cop_dispatch; watchdog scenario follows SCARV_COP_DISPATCH_TIMEOUT_EN.
module tb_scarv_cop_dispatch;
  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  int checks = 0;
  int errors = 0;

  scarv_cop_dispatch_if bus();

  scarv_cop_dispatch #(.TIMEOUT_CYCLES(16)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pipe_valid = 1'b0; bus.pipe_insn = 32'd0; bus.pipe_rs1 = 32'd0; bus.pipe_flush = 1'b0;
    bus.res_ready = 1'b0; bus.cop_insn_ack = 1'b0; bus.cop_insn_rsp = 1'b0;
    bus.cop_wen = 1'b0; bus.cop_waddr = 5'd0; bus.cop_wdata = 32'd0; bus.cop_result = 3'd0;
  endtask

  task automatic issue_and_ack(input logic [31:0] insn, input logic [31:0] rs1);
    bus.pipe_valid = 1'b1; bus.pipe_insn = insn; bus.pipe_rs1 = rs1;
    step();
    bus.pipe_valid = 1'b0; bus.cop_insn_ack = 1'b1;
    step();
    bus.cop_insn_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    g_resetn = 1'b0;
    step(); step();
    checks++;
    if ({bus.pipe_ready, bus.res_valid, bus.res_wen, bus.res_timeout, bus.cpu_insn_req,
         bus.cpu_abort_req, bus.cpu_insn_ack, bus.busy} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {bus.pipe_ready, bus.res_valid, bus.res_wen, bus.res_timeout, bus.cpu_insn_req,
         bus.cpu_abort_req, bus.cpu_insn_ack, bus.busy});
    end
    checks++;
    if ({bus.res_waddr, bus.res_wdata, bus.res_result, bus.cpu_insn_enc, bus.cpu_rs1} !== 104'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0",
        {bus.res_waddr, bus.res_wdata, bus.res_result, bus.cpu_insn_enc, bus.cpu_rs1});
    end
    g_resetn = 1'b1;
    step();
    checks++;
    if ({bus.pipe_ready, bus.cpu_insn_ack, bus.busy} !== 3'b110) begin
      errors++; $display("FAIL post_reset: got %b expected 110", {bus.pipe_ready, bus.cpu_insn_ack, bus.busy});
    end
  endtask

  task automatic test_basic();
    bus.pipe_valid = 1'b1; bus.pipe_insn = 32'h0000_502B; bus.pipe_rs1 = 32'h0000_1234;
    step();
    bus.pipe_valid = 1'b0;
    checks++;
    if ({bus.cpu_insn_req, bus.pipe_ready, bus.busy, bus.cpu_insn_enc, bus.cpu_rs1} !== {3'b101, 32'h0000_502B, 32'h0000_1234}) begin
      errors++; $display("FAIL basic_issue: got req/rdy/busy=%b enc=%h rs1=%h expected 101 0000502b 00001234",
        {bus.cpu_insn_req, bus.pipe_ready, bus.busy}, bus.cpu_insn_enc, bus.cpu_rs1);
    end
    bus.cop_insn_ack = 1'b1;
    step();
    bus.cop_insn_ack = 1'b0;
    checks++;
    if (bus.cpu_insn_req !== 1'b0) begin
      errors++; $display("FAIL basic_req_drop: got %b expected 0", bus.cpu_insn_req);
    end
    step();
    bus.cop_insn_rsp = 1'b1; bus.cop_wen = 1'b1; bus.cop_waddr = 5'd5;
    bus.cop_wdata = 32'hDEAD_BEEF; bus.cop_result = 3'd0;
    step();
    bus.cop_insn_rsp = 1'b0;
    checks++;
    if ({bus.res_valid, bus.res_wen, bus.res_waddr, bus.res_wdata, bus.res_result, bus.res_timeout} !==
        {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0, 1'b0}) begin
      errors++; $display("FAIL basic_result: got v=%b wen=%b waddr=%0d wdata=%h res=%0d to=%b expected 1 1 5 deadbeef 0 0",
        bus.res_valid, bus.res_wen, bus.res_waddr, bus.res_wdata, bus.res_result, bus.res_timeout);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy, bus.pipe_ready} !== 3'b001) begin
      errors++; $display("FAIL basic_retire: got v/busy/rdy=%b expected 001", {bus.res_valid, bus.busy, bus.pipe_ready});
    end
  endtask

  task automatic test_min_latency();
    bus.pipe_valid = 1'b1; bus.pipe_insn = 32'h0000_702B; bus.pipe_rs1 = 32'h1;
    step();
    bus.pipe_valid = 1'b0; bus.cop_insn_ack = 1'b1;
    step();
    bus.cop_insn_ack = 1'b0;
    bus.cop_insn_rsp = 1'b1; bus.cop_wen = 1'b1; bus.cop_waddr = 5'd1; bus.cop_wdata = 32'h2; bus.cop_result = 3'd0;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL min_lat_early: got %b expected 0", bus.res_valid);
    end
    step();
    bus.cop_insn_rsp = 1'b0;
    checks++;
    if ({bus.res_valid, bus.pipe_ready, bus.res_wdata} !== {2'b10, 32'h2}) begin
      errors++; $display("FAIL min_lat: got v/rdy=%b wdata=%h expected 10 00000002", {bus.res_valid, bus.pipe_ready}, bus.res_wdata);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_stall();
    bus.pipe_valid = 1'b1; bus.pipe_insn = 32'hA5A5_0001; bus.pipe_rs1 = 32'h0000_5555;
    step();
    bus.pipe_valid = 1'b0; bus.pipe_insn = 32'hFFFF_FFFF; bus.pipe_rs1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus.cpu_insn_req, bus.cpu_insn_enc, bus.cpu_rs1} !== {1'b1, 32'hA5A5_0001, 32'h0000_5555}) begin
        errors++; $display("FAIL stall_hold[%0d]: got req=%b enc=%h rs1=%h expected 1 a5a50001 00005555",
          i, bus.cpu_insn_req, bus.cpu_insn_enc, bus.cpu_rs1);
      end
    end
    bus.cop_insn_ack = 1'b1;
    step();
    bus.cop_insn_ack = 1'b0;
    checks++;
    if ({bus.cpu_insn_req, bus.busy, bus.res_valid} !== 3'b010) begin
      errors++; $display("FAIL stall_handshake: got req/busy/v=%b expected 010", {bus.cpu_insn_req, bus.busy, bus.res_valid});
    end
    bus.cop_insn_rsp = 1'b1; bus.cop_wen = 1'b1; bus.cop_waddr = 5'd7; bus.cop_wdata = 32'h0BAD_F00D; bus.cop_result = 3'd0;
    step();
    bus.cop_insn_rsp = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_backpressure_errcode();
    issue_and_ack(32'h0000_302B, 32'h1);
    bus.cop_insn_rsp = 1'b1; bus.cop_wen = 1'b0; bus.cop_waddr = 5'd3; bus.cop_wdata = 32'h1111_2222; bus.cop_result = 3'b011;
    step();
    bus.cop_insn_rsp = 1'b0; bus.cop_wen = 1'b1; bus.cop_waddr = 5'd31; bus.cop_wdata = 32'hFFFF_FFFF; bus.cop_result = 3'b111;
    checks++;
    if ({bus.res_result, bus.res_wen} !== 4'b0110) begin
      errors++; $display("FAIL err_code: got result=%b wen=%b expected 011 0", bus.res_result, bus.res_wen);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus.res_valid, bus.pipe_ready, bus.res_waddr, bus.res_wdata, bus.res_result} !== {2'b10, 5'd3, 32'h1111_2222, 3'b011}) begin
        errors++; $display("FAIL bp_stable[%0d]: got v/rdy=%b waddr=%0d wdata=%h res=%b expected 10 3 11112222 011",
          i, {bus.res_valid, bus.pipe_ready}, bus.res_waddr, bus.res_wdata, bus.res_result);
      end
      step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.res_valid, bus.pipe_ready, bus.busy} !== 3'b010) begin
      errors++; $display("FAIL bp_release: got v/rdy/busy=%b expected 010", {bus.res_valid, bus.pipe_ready, bus.busy});
    end
  endtask

  task automatic test_flush_wait();
    logic seen_valid;
    int abort_cycles;
    seen_valid = 1'b0;
    abort_cycles = 0;
    issue_and_ack(32'h0000_102B, 32'h0);
    bus.pipe_flush = 1'b1;
    step();
    bus.pipe_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.cpu_abort_req === 1'b1) abort_cycles++;
      if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
      step();
    end
    checks++;
    if (abort_cycles != 1) begin
      errors++; $display("FAIL flush_abort_len: got %0d cycles expected 1", abort_cycles);
    end
    checks++;
    if ({bus.busy, bus.pipe_ready} !== 2'b10) begin
      errors++; $display("FAIL flush_wait_hold: got busy/rdy=%b expected 10", {bus.busy, bus.pipe_ready});
    end
    bus.cop_insn_rsp = 1'b1; bus.cop_wen = 1'b1; bus.cop_wdata = 32'hCAFE_0000;
    step();
    bus.cop_insn_rsp = 1'b0;
    if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    step();
    if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    checks++;
    if ({seen_valid, bus.pipe_ready, bus.busy} !== 3'b010) begin
      errors++; $display("FAIL flush_retire: got seen_v/rdy/busy=%b expected 010", {seen_valid, bus.pipe_ready, bus.busy});
    end
  endtask

  task automatic test_flush_issue();
    bus.pipe_valid = 1'b1; bus.pipe_flush = 1'b1; bus.pipe_insn = 32'h0000_202B;
    step();
    checks++;
    if ({bus.busy, bus.cpu_insn_req} !== 2'b00) begin
      errors++; $display("FAIL valid_with_flush: got busy/req=%b expected 00", {bus.busy, bus.cpu_insn_req});
    end
    bus.pipe_flush = 1'b0;
    step();
    bus.pipe_valid = 1'b0; bus.pipe_flush = 1'b1;
    checks++;
    if (bus.cpu_insn_req !== 1'b1) begin
      errors++; $display("FAIL flush_issue_req: got %b expected 1", bus.cpu_insn_req);
    end
    step();
    bus.pipe_flush = 1'b0;
    checks++;
    if ({bus.cpu_insn_req, bus.cpu_abort_req, bus.busy, bus.pipe_ready} !== 4'b0001) begin
      errors++; $display("FAIL flush_issue: got req/abort/busy/rdy=%b expected 0001",
        {bus.cpu_insn_req, bus.cpu_abort_req, bus.busy, bus.pipe_ready});
    end
  endtask

  task automatic test_stale_rsp();
    bus.cop_insn_rsp = 1'b1; bus.cop_wen = 1'b1; bus.cop_wdata = 32'h5A5A_5A5A;
    step();
    bus.cop_insn_rsp = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy, bus.pipe_ready, bus.cpu_insn_ack} !== 4'b0011) begin
      errors++; $display("FAIL stale_rsp: got v/busy/rdy/ack=%b expected 0011",
        {bus.res_valid, bus.busy, bus.pipe_ready, bus.cpu_insn_ack});
    end
  endtask

  task automatic test_reset_mid();
    issue_and_ack(32'h0000_402B, 32'h9);
    g_resetn = 1'b0;
    step();
    checks++;
    if ({bus.pipe_ready, bus.busy, bus.cpu_insn_ack, bus.cpu_insn_enc, bus.cpu_rs1} !== 67'd0) begin
      errors++; $display("FAIL reset_mid: got rdy/busy/ack=%b enc=%h rs1=%h expected 000 0 0",
        {bus.pipe_ready, bus.busy, bus.cpu_insn_ack}, bus.cpu_insn_enc, bus.cpu_rs1);
    end
    g_resetn = 1'b1;
    bus.cop_insn_rsp = 1'b1; bus.cop_wen = 1'b1;
    step();
    bus.cop_insn_rsp = 1'b0;
    step();
    checks++;
    if ({bus.res_valid, bus.busy, bus.pipe_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_mid_recover: got v/busy/rdy=%b expected 001", {bus.res_valid, bus.busy, bus.pipe_ready});
    end
  endtask

  task automatic test_timeout();
    logic seen_valid;
    seen_valid = 1'b0;
    bus.cop_wen = 1'b1; bus.cop_waddr = 5'd9; bus.cop_wdata = 32'h7777_7777; bus.cop_result = 3'd5;
    issue_and_ack(32'h0000_602B, 32'h3);
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_early: got res_valid before limit expected none");
    end
    step();
    checks++;
    if ({bus.res_valid, bus.res_timeout, bus.res_wen, bus.res_result, bus.cpu_abort_req} !== 7'b1100001) begin
      errors++; $display("FAIL tmo_fire: got v/to/wen/res/abort=%b expected 1100001",
        {bus.res_valid, bus.res_timeout, bus.res_wen, bus.res_result, bus.cpu_abort_req});
    end
    step();
    checks++;
    if (bus.cpu_abort_req !== 1'b0) begin
      errors++; $display("FAIL tmo_abort_pulse: got %b expected 0", bus.cpu_abort_req);
    end
    step();
    bus.cop_insn_rsp = 1'b1;
    step();
    bus.cop_insn_rsp = 1'b0;
    checks++;
    if ({bus.res_valid, bus.res_timeout, bus.res_wen, bus.res_result} !== 6'b110000) begin
      errors++; $display("FAIL tmo_stale: got v/to/wen/res=%b expected 110000",
        {bus.res_valid, bus.res_timeout, bus.res_wen, bus.res_result});
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL tmo_retire: got v/busy=%b expected 00", {bus.res_valid, bus.busy});
    end
`else
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if ({seen_valid, bus.busy, bus.res_timeout} !== 3'b010) begin
      errors++; $display("FAIL no_tmo: got seen_v/busy/to=%b expected 010", {seen_valid, bus.busy, bus.res_timeout});
    end
    bus.cop_insn_rsp = 1'b1;
    step();
    bus.cop_insn_rsp = 1'b0;
    checks++;
    if ({bus.res_valid, bus.res_wdata, bus.res_result} !== {1'b1, 32'h7777_7777, 3'd5}) begin
      errors++; $display("FAIL no_tmo_late_rsp: got v=%b wdata=%h res=%0d expected 1 77777777 5",
        bus.res_valid, bus.res_wdata, bus.res_result);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_latency();
    test_stall();
    test_backpressure_errcode();
    test_flush_wait();
    test_flush_issue();
    test_stale_rsp();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
